// File: rtl/rx_frame_writer.sv
// ---------------------------------------------------------------------------
// rx_frame_writer
//   Packs received radio payload bytes into 16-bit SRAM words. Each frame is
//   written as a sync word (16'h2DD4), then {length, byte0}, then byte pairs
//   with the earlier byte in the high half. An odd trailing byte is padded
//   with 8'h00 in the low half. An aborted frame is completed with zero bytes
//   so the SRAM word count always matches the advertised length.
//
// Ports
//   clk              : system clock, rising edge
//   reset_n          : asynchronous active-low reset
//   Rx_start         : one-cycle frame start strobe, Rx_len valid with it
//   Rx_len[7:0]      : payload byte count
//   Rx_data[7:0]     : payload byte
//   Rx_data_valid    : Rx_data valid, held by upstream until accepted
//   Rx_ready         : byte accepted when Rx_data_valid && Rx_ready
//   Rx_abort         : upstream abandons the current frame
//   SRAM_write       : SRAM write request
//   SRAM_hint        : SRAM write acknowledge
//   SRAM_full        : SRAM buffer full, blocks new writes and byte intake
//   Data_to_sram     : SRAM write word
//   Pkt_Received_int : one-cycle pulse once a whole frame is in SRAM
//   Drop_count       : rejected Rx_start strobes, saturating at 255
//   Abort_count      : aborted frames, saturating at 255
//   Writer_Status    : FSM state (IDLE=0 HDR=1 GET0=2 GETH=3 GETL=4 WR=5 DONE=6)
//
// Handshakes
//   Byte side : a byte transfers on a rising edge where Rx_data_valid and
//               Rx_ready are both high; Rx_ready never depends on Rx_data_valid.
//   SRAM side : SRAM_write is raised only when SRAM_full was low, then held
//               with Data_to_sram stable until SRAM_hint is sampled high; it is
//               low on the next cycle and stays low at least one cycle before
//               the following write.
// ---------------------------------------------------------------------------
module rx_frame_writer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Rx_start,
  input  logic [7:0]  Rx_len,
  input  logic [7:0]  Rx_data,
  input  logic        Rx_data_valid,
  output logic        Rx_ready,
  input  logic        Rx_abort,
  output logic        SRAM_write,
  input  logic        SRAM_hint,
  input  logic        SRAM_full,
  output logic [15:0] Data_to_sram,
  output logic        Pkt_Received_int,
  output logic [7:0]  Drop_count,
  output logic [7:0]  Abort_count,
  output logic [3:0]  Writer_Status
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_HDR  = 4'd1,
    S_GET0 = 4'd2,
    S_GETH = 4'd3,
    S_GETL = 4'd4,
    S_WR   = 4'd5,
    S_DONE = 4'd6
  } state_t;

  localparam logic [15:0] SYNC_WORD = 16'h2DD4;

  state_t     state;
  logic [7:0] len_q;
  logic [7:0] rem_q;        // payload bytes still to be packed
  logic [7:0] hi_q;         // high byte of the pair being assembled
  logic       abort_pend_q; // abort seen, not yet applied to a byte
  logic       abort_act_q;  // abort applied: remaining bytes become 8'h00

  logic       in_get;
  logic       take;
  logic       fill;
  logic       got;
  logic [7:0] byte_v;
  logic [7:0] rem_dec;
  logic       drop_evt;

  assign in_get = (state == S_GET0) || (state == S_GETH) || (state == S_GETL);

  // Intake stops once an abort is known and while the SRAM is full, so
  // nothing is taken in that could not eventually be written.
  assign Rx_ready = in_get && !abort_pend_q && !abort_act_q && !SRAM_full;

  assign Writer_Status = state;

  always_comb begin
    take     = Rx_ready && Rx_data_valid;
    // After an abort each GET state consumes a zero byte without a handshake.
    fill     = in_get && !take && (abort_pend_q || abort_act_q || Rx_abort);
    got      = take || fill;
    byte_v   = take ? Rx_data : 8'h00;
    rem_dec  = (rem_q != 8'd0) ? (rem_q - 8'd1) : 8'd0;
    drop_evt = Rx_start && ((state != S_IDLE) || (Rx_len == 8'd0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      len_q            <= 8'd0;
      rem_q            <= 8'd0;
      hi_q             <= 8'd0;
      abort_pend_q     <= 1'b0;
      abort_act_q      <= 1'b0;
      SRAM_write       <= 1'b0;
      Data_to_sram     <= 16'h0000;
      Pkt_Received_int <= 1'b0;
      Drop_count       <= 8'd0;
      Abort_count      <= 8'd0;
    end else begin
      Pkt_Received_int <= 1'b0;

      if (drop_evt && (Drop_count != 8'hFF)) begin
        Drop_count <= Drop_count + 8'd1;
      end

      // Abort bookkeeping shared by the three GET states.
      if (in_get) begin
        if (take && Rx_abort) begin
          abort_pend_q <= 1'b1;
        end
        if (fill && !abort_act_q) begin
          abort_act_q  <= 1'b1;
          abort_pend_q <= 1'b0;
          if (Abort_count != 8'hFF) begin
            Abort_count <= Abort_count + 8'd1;
          end
        end
      end

      case (state)
        S_IDLE: begin
          // Rx_start wins over a simultaneous Rx_abort here.
          if (Rx_start && (Rx_len != 8'd0)) begin
            len_q        <= Rx_len;
            rem_q        <= Rx_len;
            abort_pend_q <= 1'b0;
            abort_act_q  <= 1'b0;
            Data_to_sram <= SYNC_WORD;
            state        <= S_HDR;
          end
        end

        S_HDR, S_WR: begin
          // An abort arriving mid-write is held until the next GET state.
          if ((state == S_WR) && Rx_abort && !abort_act_q) begin
            abort_pend_q <= 1'b1;
          end
          if (!SRAM_write) begin
            if (!SRAM_full) begin
              SRAM_write <= 1'b1;
            end
          end else if (SRAM_hint) begin
            SRAM_write <= 1'b0;
            if (state == S_HDR) begin
              state <= S_GET0;
            end else if (rem_q == 8'd0) begin
              Pkt_Received_int <= 1'b1;
              state            <= S_DONE;
            end else begin
              state <= S_GETH;
            end
          end
        end

        S_GET0: begin
          if (got) begin
            Data_to_sram <= {len_q, byte_v};
            rem_q        <= rem_dec;
            state        <= S_WR;
          end
        end

        S_GETH: begin
          if (got) begin
            rem_q <= rem_dec;
            if (rem_q == 8'd1) begin
              Data_to_sram <= {byte_v, 8'h00};
              state        <= S_WR;
            end else begin
              hi_q  <= byte_v;
              state <= S_GETL;
            end
          end
        end

        S_GETL: begin
          if (got) begin
            Data_to_sram <= {hi_q, byte_v};
            rem_q        <= rem_dec;
            state        <= S_WR;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_writer
//   Scoreboard bench for rx_frame_writer. Frame tasks compute the expected
//   SRAM word sequence from the framing rules and push it into exp_q; an
//   independent monitor pops and compares on every SRAM write acknowledge,
//   and checks the write/full/pulse protocol each cycle.
// ---------------------------------------------------------------------------
module tb_rx_frame_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Rx_start;
  logic [7:0]  Rx_len;
  logic [7:0]  Rx_data;
  logic        Rx_data_valid;
  logic        Rx_ready;
  logic        Rx_abort;
  logic        SRAM_write;
  logic        SRAM_hint;
  logic        SRAM_full;
  logic [15:0] Data_to_sram;
  logic        Pkt_Received_int;
  logic [7:0]  Drop_count;
  logic [7:0]  Abort_count;
  logic [3:0]  Writer_Status;

  rx_frame_writer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .Rx_start         (Rx_start),
    .Rx_len           (Rx_len),
    .Rx_data          (Rx_data),
    .Rx_data_valid    (Rx_data_valid),
    .Rx_ready         (Rx_ready),
    .Rx_abort         (Rx_abort),
    .SRAM_write       (SRAM_write),
    .SRAM_hint        (SRAM_hint),
    .SRAM_full        (SRAM_full),
    .Data_to_sram     (Data_to_sram),
    .Pkt_Received_int (Pkt_Received_int),
    .Drop_count       (Drop_count),
    .Abort_count      (Abort_count),
    .Writer_Status    (Writer_Status)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          exp_drop = 0;
  int          exp_abort = 0;
  int          exp_pulses = 0;
  int          pulses_seen = 0;
  int          words_seen = 0;
  int          full_cycles = 0;
  bit          mon_en = 1'b1;
  bit          immediate_hint = 1'b1;
  bit          rand_full_en = 1'b0;
  int          force_cnt = 0;
  int          full_cnt = 0;
  logic [7:0]  fb[256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // ---------------- SRAM responder ----------------
  // Drives hint/full just after each rising edge. Full is only raised while
  // no write is outstanding, so a held write is never caught by it.
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      SRAM_hint = 1'b0;
      SRAM_full = 1'b0;
      force_cnt = 0;
      full_cnt  = 0;
    end else begin
      SRAM_hint = SRAM_write && (immediate_hint || ($urandom_range(0, 2) != 0));
      if (force_cnt > 0 && (SRAM_full || !SRAM_write)) begin
        force_cnt--;
        SRAM_full = 1'b1;
      end else if (full_cnt > 0) begin
        full_cnt--;
        SRAM_full = 1'b1;
      end else if (rand_full_en && !SRAM_write && ($urandom_range(0, 7) == 0)) begin
        full_cnt  = $urandom_range(0, 3);
        SRAM_full = 1'b1;
      end else begin
        SRAM_full = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        prev_write, prev_hint, prev_pkt;
  logic [15:0] prev_data;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_write = 1'b0;
      prev_hint  = 1'b0;
      prev_pkt   = 1'b0;
      prev_data  = 16'h0;
    end else begin
      if (mon_en) begin
        if (prev_write && prev_hint) begin
          chk("write_low_after_hint", {31'd0, SRAM_write}, 32'd0);
        end else if (prev_write) begin
          chk("write_hold", {31'd0, SRAM_write}, 32'd1);
          chk("data_hold", {16'd0, Data_to_sram}, {16'd0, prev_data});
        end
        if (SRAM_full) begin
          full_cycles++;
          chk("full_write_low", {31'd0, SRAM_write}, 32'd0);
          chk("full_ready_low", {31'd0, Rx_ready}, 32'd0);
        end
        if (SRAM_write && SRAM_hint) begin
          words_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got %0h expected no write at %0t", Data_to_sram, $time);
          end else begin
            chk("sram_word", {16'd0, Data_to_sram}, {16'd0, exp_q.pop_front()});
          end
        end
      end
      if (Pkt_Received_int) begin
        pulses_seen++;
        chk("pulse_width", {31'd0, prev_pkt}, 32'd0);
        chk("frame_words_left", exp_q.size(), 32'd0);
      end
      prev_write = SRAM_write;
      prev_hint  = SRAM_hint;
      prev_pkt   = Pkt_Received_int;
      prev_data  = Data_to_sram;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic feed_byte(input logic [7:0] b, input bit stray);
    bit ok;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    if (stray && ($urandom_range(0, 5) == 0)) begin
      // Frame is mid-flight here, so this start must be dropped.
      Rx_start = 1'b1;
      Rx_len   = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      Rx_start = 1'b0;
      exp_drop++;
    end
    Rx_data       = b;
    Rx_data_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (Rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      chk("byte_accept_timeout", 32'd0, 32'd1);
    end
    Rx_data_valid = 1'b0;
    Rx_data       = 8'($urandom_range(0, 255));
  endtask

  // Expected words come straight from the framing rules: sync word,
  // {len, byte0}, then pairs high-first with zero pad; aborted bytes are 0.
  task automatic run_frame(input int len, input int abort_after, input bit start_abort,
                           input bit stray);
    logic [7:0] eb[256];
    logic [7:0] l8;
    int         base;
    l8 = 8'(len);
    for (int i = 0; i < len; i++) begin
      eb[i] = (abort_after > 0 && i >= abort_after) ? 8'h00 : fb[i];
    end
    if (len > 0) begin
      exp_q.push_back(16'h2DD4);
      exp_q.push_back({l8, eb[0]});
      for (int j = 1; j < len; j += 2) begin
        exp_q.push_back({eb[j], (j + 1 < len) ? eb[j + 1] : 8'h00});
      end
      exp_pulses++;
    end
    base     = pulses_seen;
    Rx_start = 1'b1;
    Rx_len   = l8;
    Rx_abort = start_abort;
    @(posedge clk);
    #1;
    Rx_start = 1'b0;
    Rx_abort = 1'b0;
    if (len == 0) begin
      exp_drop++;
      repeat (3) begin
        @(posedge clk);
        #1;
      end
    end else begin
      for (int i = 0; i < ((abort_after > 0) ? abort_after : len); i++) begin
        feed_byte(fb[i], stray);
      end
      if (abort_after > 0) begin
        exp_abort++;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
        Rx_abort = 1'b1;
        @(posedge clk);
        #1;
        Rx_abort = 1'b0;
      end
      for (int t = 0; t < 5000 && pulses_seen == base; t++) begin
        @(negedge clk);
      end
      if (pulses_seen == base) begin
        chk("frame_pulse_timeout", 32'd0, 32'd1);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_write"}, {31'd0, SRAM_write}, 32'd0);
    chk({tag, "_ready"}, {31'd0, Rx_ready}, 32'd0);
    chk({tag, "_pulse"}, {31'd0, Pkt_Received_int}, 32'd0);
    chk({tag, "_data"}, {16'd0, Data_to_sram}, 32'd0);
    chk({tag, "_drop"}, {24'd0, Drop_count}, 32'd0);
    chk({tag, "_abort"}, {24'd0, Abort_count}, 32'd0);
    chk({tag, "_state"}, {28'd0, Writer_Status}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base_w;
    int fc0;
    int len;
    int ab;
    reset_n       = 1'b0;
    Rx_start      = 1'b0;
    Rx_len        = 8'h00;
    Rx_data       = 8'h00;
    Rx_data_valid = 1'b0;
    Rx_abort      = 1'b0;
    SRAM_hint     = 1'b0;
    SRAM_full     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Directed frames with immediate acknowledge.
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44; fb[4] = 8'h55;
    run_frame(5, 0, 1'b0, 1'b0);
    fb[0] = 8'hA1; fb[1] = 8'hA2; fb[2] = 8'hA3; fb[3] = 8'hA4;
    run_frame(4, 0, 1'b0, 1'b0);
    fb[0] = 8'h7E;
    run_frame(1, 0, 1'b0, 1'b0);
    run_frame(0, 0, 1'b0, 1'b0);
    chk("len0_drop", {24'd0, Drop_count}, 32'd1);
    chk("len0_pulses", pulses_seen, exp_pulses);

    // Full held for 20 cycles while word2 is pending.
    for (int i = 0; i < 6; i++) fb[i] = 8'($urandom_range(0, 255));
    base_w = words_seen;
    fc0    = full_cycles;
    fork
      run_frame(6, 0, 1'b0, 1'b0);
      begin
        for (int t = 0; t < 2000 && words_seen < base_w + 2; t++) @(negedge clk);
        force_cnt = 20;
      end
    join
    chk("full_window_len", {31'd0, (full_cycles - fc0) >= 20}, 32'd1);

    // Abort after three bytes.
    for (int i = 0; i < 6; i++) fb[i] = 8'(i + 1);
    run_frame(6, 3, 1'b0, 1'b0);
    chk("abort_count_one", {24'd0, Abort_count}, 32'd1);

    // Start and abort together in IDLE: start wins.
    for (int i = 0; i < 3; i++) fb[i] = 8'($urandom_range(0, 255));
    run_frame(3, 0, 1'b1, 1'b0);
    chk("start_beats_abort", {24'd0, Abort_count}, 32'd1);

    // Randomized frames with slow acknowledge, random full and stray starts.
    immediate_hint = 1'b0;
    rand_full_en   = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
      ab  = 0;
      if (len >= 2 && $urandom_range(0, 4) == 0) ab = $urandom_range(1, len - 1);
      for (int i = 0; i < len; i++) fb[i] = 8'($urandom_range(0, 255));
      run_frame(len, ab, 1'b0, 1'b1);
    end
    chk("rand_drop", {24'd0, Drop_count}, sat255(exp_drop));
    chk("rand_abort", {24'd0, Abort_count}, sat255(exp_abort));
    chk("rand_pulses", pulses_seen, exp_pulses);

    // Reset in the middle of a frame: no pulse, everything cleared.
    rand_full_en   = 1'b0;
    immediate_hint = 1'b1;
    mon_en         = 1'b0;
    for (int i = 0; i < 8; i++) fb[i] = 8'($urandom_range(0, 255));
    Rx_start = 1'b1;
    Rx_len   = 8'd8;
    @(posedge clk);
    #1;
    Rx_start = 1'b0;
    for (int i = 0; i < 3; i++) feed_byte(fb[i], 1'b0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    exp_drop  = 0;
    exp_abort = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("midreset_no_pulse", pulses_seen, exp_pulses);
    mon_en  = 1'b1;
    reset_n = 1'b1;
    // Start is driven in the same cycle reset is released.
    for (int i = 0; i < 4; i++) fb[i] = 8'($urandom_range(0, 255));
    run_frame(4, 0, 1'b0, 1'b0);

    // Drop counter saturation.
    Rx_start = 1'b1;
    Rx_len   = 8'd0;
    repeat (260) @(posedge clk);
    #1;
    Rx_start = 1'b0;
    exp_drop += 260;
    @(posedge clk);
    #1;
    chk("drop_saturate", {24'd0, Drop_count}, sat255(exp_drop));
    chk("final_abort", {24'd0, Abort_count}, sat255(exp_abort));
    chk("final_pulses", pulses_seen, exp_pulses);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    chk("final_state_idle", {28'd0, Writer_Status}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
